pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Controller that owns the program counter register and the instruction-memory fetch port of the MIPS core. It generates the PC register's enable and next-value inputs, issues fetch requests with a req/ack handshake, and holds a fetched instruction while decode is stalled. It also redirects the PC on taken branches and jumps, including redirects that arrive while a fetch is still outstanding. It sits between the PC register, instruction memory and the ID stage.

## Interface
- N, 32, PC and address width
- RESET_PC, 32'h0040_0000, boot address loaded into the PC after reset
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- pc_value  in  N  current PC register output
- pc_enable  out  1  PC register enable
- next_pc  out  N  PC register next value; bits [1:0] always 0
- imem_req  out  1  fetch request, held high until acknowledged
- imem_addr  out  N  fetch address (= pc_value while imem_req)
- imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid with imem_ack
- stall  in  1  decode cannot accept an instruction this cycle
- branch_taken  in  1  single-cycle pulse, EX-stage branch resolved taken
- branch_target  in  N  branch destination, valid with branch_taken
- jump  in  1  single-cycle pulse, ID-stage jump
- jump_target  in  N  jump destination, valid with jump
- fetch_valid  out  1  fetch_instr/fetch_pc valid for decode
- fetch_instr  out  32  instruction delivered to decode
- fetch_pc  out  N  address of fetch_instr
- flush  out  1  one-cycle pulse: decode must discard its current instruction

## Operation
- Redirect request this cycle = branch_taken | jump. If both are high, branch_taken wins because it belongs to the older instruction. Target bits [1:0] are forced to 0.
- Sequential PC: pc_value + 4, modulo 2^N; 0xFFFF_FFFC wraps to 0.
- The FSM has three states: BOOT, FETCH and HOLD.
- BOOT:
  - pc_enable=1, next_pc=RESET_PC, imem_req=0.
  - Redirects are ignored.
  - Next state: FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_value.
  - Redirect arrives, no ack: capture the target in a pending register and set pend=1. A later redirect overwrites the pending target. flush=1 in each such cycle.
  - Ack arrives and (pend or redirect this cycle): discard the response (fetch_valid=0). Load the target with pc_enable=1; a same-cycle redirect wins over pend. Clear pend. Assert flush=1. Stay in FETCH.
  - Ack, no redirect, stall=0: fetch_valid=1, fetch_instr=imem_rdata, fetch_pc=pc_value. pc_enable=1, next_pc=pc_value+4. Stay in FETCH.
  - Ack, no redirect, stall=1: latch imem_rdata and pc_value into hold registers, pc_enable=0, go to HOLD.
- HOLD:
  - imem_req=0.
  - fetch_valid=1, with fetch_instr and fetch_pc driven from the hold registers.
  - Redirect: fetch_valid=0, flush=1, pc_enable=1, next_pc=target, go to FETCH.
  - Else stall=0: the instruction is consumed this cycle. pc_enable=1, next_pc=pc_value+4, go to FETCH.
  - Else (stall=1): remain in HOLD, pc_enable=0.
- A redirect always overrides stall.
- In all states, outputs not listed above are 0. fetch_instr and fetch_pc are don't-care when fetch_valid=0.

## Timing
- While reset=1:
  - All outputs are 0.
  - The state register is forced to BOOT and pend is cleared.
  - Hold registers are cleared to 0.
- The first cycle with reset=0 is BOOT. The first imem_req rises in the next cycle, at address RESET_PC.
- Outputs are a combinational function of state, registers and current inputs. Same-cycle ack is legal.
- Throughput is one instruction per cycle when imem_ack is tied high and stall=0.
- Redirect latency:
  - Redirect in cycle t, in FETCH with ack or in HOLD: the PC register holds the target after edge t, and imem_req for the target is issued in cycle t+1.
  - Redirect during an un-acked fetch: the target is loaded in the cycle the outstanding ack arrives.
- The outstanding request is never abandoned; imem_req stays high until imem_ack.
- Reset mid-fetch: the request drops immediately. Instruction memory shares this reset, so no stale ack follows.

## Test plan
- **Boot and stream:** release reset with imem_ack tied 1, stall=0. Required: one BOOT cycle with next_pc=0x0040_0000, then fetch_pc 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles, fetch_valid=1 each cycle.
- **Wait states:** ack 3 cycles after imem_req at PC 0x0040_0010. Required: imem_req high for all 3 cycles, a single fetch_valid pulse, then next_pc=0x0040_0014.
- **Stall hold:** stall=1 for 4 cycles after a fetch of instruction 0x2008_0005 at PC 0x0040_0020. Required:
  - HOLD with fetch_valid=1 and fetch_instr=0x2008_0005 throughout.
  - pc_enable=0 and imem_req=0 while stalled.
  - PC advances to 0x0040_0024 in the cycle stall drops.
- **Redirect during wait:** jump to 0x0040_0100 while ack is pending, then branch_taken to 0x0040_0200 one cycle later, then ack. Required: flush pulse in both cycles, response discarded, next_pc=0x0040_0200.
- **Simultaneous events:** both redirects are tested while in HOLD with stall=1.
  - branch_taken (target 0x0040_0300) and jump (target 0x0040_0400) together. Required: next_pc=0x0040_0300, flush=1, fetch_valid=0.
  - Target 0x0040_0303 (misaligned). Required: next_pc=0x0040_0300.
- **Wrap and reset:** force pc_value=0xFFFF_FFFC. Required: next_pc=0. Then assert reset mid-wait. Required: all outputs 0 immediately, BOOT on release, and a fetch from RESET_PC with no pend carried over.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns PC register control and the instruction-memory
// fetch handshake. Holds a fetched instruction while decode stalls and
// steers the PC on branch/jump redirects, including redirects that land
// while a fetch is still waiting for its acknowledge.
module pc_fetch_sequencer #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pc_value,
  output logic          pc_enable,
  output logic [N-1:0]  next_pc,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [N-1:0]  branch_target,
  input  logic          jump,
  input  logic [N-1:0]  jump_target,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic [N-1:0]  fetch_pc,
  output logic          flush
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [N-1:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]   hold_instr_q, hold_instr_d;
  logic [N-1:0]  hold_pc_q, hold_pc_d;

  logic          redir;
  logic [N-1:0]  redir_tgt;
  logic [N-1:0]  pc_plus4;

  // Word-align an address; instruction fetches are always 4-byte aligned.
  function automatic logic [N-1:0] align_word(input logic [N-1:0] a);
    return {a[N-1:2], 2'b00};
  endfunction

  // Branch belongs to the older instruction, so it beats a same-cycle jump.
  assign redir     = branch_taken | jump;
  assign redir_tgt = align_word(branch_taken ? branch_target : jump_target);
  assign pc_plus4  = pc_value + N'(4);

  logic          pc_enable_c;
  logic [N-1:0]  next_pc_c;
  logic          imem_req_c;
  logic [N-1:0]  imem_addr_c;
  logic          fetch_valid_c;
  logic [31:0]   fetch_instr_c;
  logic [N-1:0]  fetch_pc_c;
  logic          flush_c;

  // Next-state and output decode; outputs are forced low while in reset.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    pc_enable_c   = 1'b0;
    next_pc_c     = '0;
    imem_req_c    = 1'b0;
    imem_addr_c   = '0;
    fetch_valid_c = 1'b0;
    fetch_instr_c = '0;
    fetch_pc_c    = '0;
    flush_c       = 1'b0;

    unique case (state_q)
      BOOT: begin
        pc_enable_c = 1'b1;
        next_pc_c   = RESET_PC;
        state_d     = FETCH;
      end
      FETCH: begin
        imem_req_c  = 1'b1;
        imem_addr_c = pc_value;
        if (imem_ack) begin
          if (redir || pend_q) begin
            // Response belongs to the wrong path: drop it and steer the PC.
            pc_enable_c = 1'b1;
            next_pc_c   = redir ? redir_tgt : pend_tgt_q;
            pend_d      = 1'b0;
            flush_c     = 1'b1;
          end else if (!stall) begin
            fetch_valid_c = 1'b1;
            fetch_instr_c = imem_rdata;
            fetch_pc_c    = pc_value;
            pc_enable_c   = 1'b1;
            next_pc_c     = pc_plus4;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_value;
            state_d      = HOLD;
          end
        end else if (redir) begin
          // Request must complete first; remember where to go afterwards.
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt;
          flush_c    = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          flush_c     = 1'b1;
          pc_enable_c = 1'b1;
          next_pc_c   = redir_tgt;
          state_d     = FETCH;
        end else begin
          fetch_valid_c = 1'b1;
          fetch_instr_c = hold_instr_q;
          fetch_pc_c    = hold_pc_q;
          if (!stall) begin
            pc_enable_c = 1'b1;
            next_pc_c   = pc_plus4;
            state_d     = FETCH;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (reset) begin
      pc_enable_c   = 1'b0;
      next_pc_c     = '0;
      imem_req_c    = 1'b0;
      imem_addr_c   = '0;
      fetch_valid_c = 1'b0;
      fetch_instr_c = '0;
      fetch_pc_c    = '0;
      flush_c       = 1'b0;
    end
  end

  assign pc_enable   = pc_enable_c;
  assign next_pc     = align_word(next_pc_c);
  assign imem_req    = imem_req_c;
  assign imem_addr   = imem_addr_c;
  assign fetch_valid = fetch_valid_c;
  assign fetch_instr = fetch_instr_c;
  assign fetch_pc    = fetch_pc_c;
  assign flush       = flush_c;

  // Control and hold registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pend_q       <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Pending redirect target is pure data, qualified by pend_q.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer. Each table row is one
// clock cycle: inputs are applied after the falling edge and the
// combinational outputs are compared shortly after, before the rising edge.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_value;
  logic        pc_enable;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.N(32), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .pc_value(pc_value),
    .pc_enable(pc_enable), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .flush(flush)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        e_pc_en;
    logic [31:0] e_npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_instr;
    logic [31:0] e_fpc;
    logic        e_flush;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic [31:0] pc, input logic ack, input logic [31:0] rdata,
    input logic stl, input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt,
    input logic pc_en, input logic [31:0] npc, input logic req, input logic [31:0] addr,
    input logic fv, input logic [31:0] instr, input logic [31:0] fpc, input logic fl);
    vec_t v;
    v.rst = rst; v.pc = pc; v.ack = ack; v.rdata = rdata; v.stall = stl;
    v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.e_pc_en = pc_en; v.e_npc = npc; v.e_req = req; v.e_addr = addr;
    v.e_fv = fv; v.e_instr = instr; v.e_fpc = fpc; v.e_flush = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset         = v.rst;
    pc_value      = v.pc;
    imem_ack      = v.ack;
    imem_rdata    = v.rdata;
    stall         = v.stall;
    branch_taken  = v.br;
    branch_target = v.bt;
    jump          = v.jp;
    jump_target   = v.jt;
    #2;
    chk({tag, " pc_enable"},   {31'd0, pc_enable},   {31'd0, v.e_pc_en});
    chk({tag, " next_pc"},     next_pc,              v.e_npc);
    chk({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, v.e_req});
    chk({tag, " imem_addr"},   imem_addr,            v.e_addr);
    chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, v.e_fv});
    chk({tag, " flush"},       {31'd0, flush},       {31'd0, v.e_flush});
    if (v.e_fv) begin
      chk({tag, " fetch_instr"}, fetch_instr, v.e_instr);
      chk({tag, " fetch_pc"},    fetch_pc,    v.e_fpc);
    end
  endtask

  initial begin
    reset = 1'b1; pc_value = '0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;

    //              rst pc            ack rdata         stl br bt            jp jt             pc_en npc           req addr          fv instr         fpc           fl
    // Reset: outputs low even with ack high and a nonzero pc
    tbl.push_back(mk(1, 32'h0000_1234, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
    // BOOT, branch ignored
    tbl.push_back(mk(0, 32'h0000_0000, 0, 32'h0,         0, 1, 32'h0000_0999, 0, 32'h0,         1, 32'h0040_0000, 0, 32'h0,         0, 32'h0,         32'h0,         0));
    // Stream, ack tied high
    tbl.push_back(mk(0, 32'h0040_0000, 1, 32'hAAAA_0001, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0004, 1, 32'h0040_0000, 1, 32'hAAAA_0001, 32'h0040_0000, 0));
    tbl.push_back(mk(0, 32'h0040_0004, 1, 32'hAAAA_0002, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0008, 1, 32'h0040_0004, 1, 32'hAAAA_0002, 32'h0040_0004, 0));
    tbl.push_back(mk(0, 32'h0040_0008, 1, 32'hAAAA_0003, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_000C, 1, 32'h0040_0008, 1, 32'hAAAA_0003, 32'h0040_0008, 0));
    tbl.push_back(mk(0, 32'h0040_000C, 1, 32'hAAAA_0004, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0010, 1, 32'h0040_000C, 1, 32'hAAAA_0004, 32'h0040_000C, 0));
    // Wait states at 0x0040_0010
    tbl.push_back(mk(0, 32'h0040_0010, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0010, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0010, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0010, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0010, 1, 32'hAAAA_0005, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0014, 1, 32'h0040_0010, 1, 32'hAAAA_0005, 32'h0040_0010, 0));
    tbl.push_back(mk(0, 32'h0040_0014, 1, 32'hAAAA_0006, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0018, 1, 32'h0040_0014, 1, 32'hAAAA_0006, 32'h0040_0014, 0));
    tbl.push_back(mk(0, 32'h0040_0018, 1, 32'hAAAA_0007, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_001C, 1, 32'h0040_0018, 1, 32'hAAAA_0007, 32'h0040_0018, 0));
    tbl.push_back(mk(0, 32'h0040_001C, 1, 32'hAAAA_0008, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0020, 1, 32'h0040_001C, 1, 32'hAAAA_0008, 32'h0040_001C, 0));
    // Stall hold: fetch 0x2008_0005 with stall, three more stalled HOLD cycles, then release
    tbl.push_back(mk(0, 32'h0040_0020, 1, 32'h2008_0005, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0020, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0020, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0040_0020, 0));
    tbl.push_back(mk(0, 32'h0040_0020, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0040_0020, 0));
    tbl.push_back(mk(0, 32'h0040_0020, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0040_0020, 0));
    tbl.push_back(mk(0, 32'h0040_0020, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0024, 0, 32'h0,         1, 32'h2008_0005, 32'h0040_0020, 0));
    // Redirect during wait: jump, then branch, then ack (discarded)
    tbl.push_back(mk(0, 32'h0040_0024, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0040_0100, 0, 32'h0,         1, 32'h0040_0024, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0024, 0, 32'h0,         0, 1, 32'h0040_0200, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0024, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0024, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0200, 1, 32'h0040_0024, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0200, 1, 32'hAAAA_0009, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0204, 1, 32'h0040_0200, 1, 32'hAAAA_0009, 32'h0040_0200, 0));
    // Simultaneous branch+jump in HOLD with stall: branch wins
    tbl.push_back(mk(0, 32'h0040_0204, 1, 32'hAAAA_000A, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0204, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0204, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'hAAAA_000A, 32'h0040_0204, 0));
    tbl.push_back(mk(0, 32'h0040_0204, 0, 32'h0,         1, 1, 32'h0040_0300, 1, 32'h0040_0400, 1, 32'h0040_0300, 0, 32'h0,         0, 32'h0,         32'h0,         1));
    // Misaligned jump target in HOLD with stall
    tbl.push_back(mk(0, 32'h0040_0300, 1, 32'hAAAA_000B, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0040_0300, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0, 32'h0040_0300, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0040_0303, 1, 32'h0040_0300, 0, 32'h0,         0, 32'h0,         32'h0,         1));
    // Same-cycle branch with ack in FETCH, misaligned target
    tbl.push_back(mk(0, 32'h0040_0300, 1, 32'hAAAA_00FF, 0, 1, 32'h0040_0503, 0, 32'h0,         1, 32'h0040_0500, 1, 32'h0040_0300, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0500, 1, 32'hAAAA_000C, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0504, 1, 32'h0040_0500, 1, 32'hAAAA_000C, 32'h0040_0500, 0));
    // Pending jump overridden by a branch arriving with the ack
    tbl.push_back(mk(0, 32'h0040_0504, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0040_0600, 0, 32'h0,         1, 32'h0040_0504, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0504, 1, 32'hAAAA_00EE, 0, 1, 32'h0040_0700, 0, 32'h0,         1, 32'h0040_0700, 1, 32'h0040_0504, 0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 32'h0040_0700, 1, 32'hAAAA_000D, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0704, 1, 32'h0040_0700, 1, 32'hAAAA_000D, 32'h0040_0700, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Wrap: sequential PC from 0xFFFF_FFFC rolls over to 0
    apply(mk(0, 32'hFFFF_FFFC, 1, 32'hAAAA_000E, 0, 0, 32'h0, 0, 32'h0,
             1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1, 32'hAAAA_000E, 32'hFFFF_FFFC, 0), "wrap");

    // Open a fetch, record a pending jump, then reset while still waiting
    apply(mk(0, 32'h0040_0040, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0,
             0, 32'h0, 1, 32'h0040_0040, 0, 32'h0, 32'h0, 0), "midwait");
    apply(mk(0, 32'h0040_0040, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0040_0800,
             0, 32'h0, 1, 32'h0040_0040, 0, 32'h0, 32'h0, 1), "midwait_jump");
    apply(mk(1, 32'h0040_0040, 0, 32'h0, 0, 1, 32'h0040_0900, 0, 32'h0,
             0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0), "reset_drop");
    apply(mk(1, 32'h0040_0040, 1, 32'h0, 1, 0, 32'h0, 0, 32'h0,
             0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0), "reset_hold");
    apply(mk(0, 32'h0040_0040, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0,
             1, 32'h0040_0000, 0, 32'h0, 0, 32'h0, 32'h0, 0), "reboot");
    // No pending target survives reset: the ack is delivered, no flush
    apply(mk(0, 32'h0040_0000, 1, 32'hAAAA_000F, 0, 0, 32'h0, 0, 32'h0,
             1, 32'h0040_0004, 1, 32'h0040_0000, 1, 32'hAAAA_000F, 32'h0040_0000, 0), "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
